nyan_sequencer: RTL
===================

NYAN_SEQUENCER -- requirements
Module: nyan_sequencer

Interface
REQ-001 Parameter NUM_FRAMES, default 2: number of animation frames; legal range 2..16.
REQ-002 Parameter DEFAULT_PERIOD, default 16: frame_start pulses per animation step after reset; legal range 1..255.
REQ-003 Parameter SPRITE_X_RESET, default 128: sprite left edge after reset, in pixels.
REQ-004 Parameter SCROLL_MAX, default 639: last legal sprite_x value before wrap.
REQ-005 clk  input  1: pixel clock, rising edge.
REQ-006 rst_n  input  1: reset; asynchronous assert, active-low.
REQ-007 frame_start  input  1: one-cycle pulse at the first pixel of vertical blanking.
REQ-008 cmd_valid  input  1: command request.
REQ-009 cmd_op  input  2: 0 PAUSE, 1 PLAY, 2 STEP, 3 SET_PERIOD.
REQ-010 cmd_data  input  8: period value for SET_PERIOD; ignored otherwise.
REQ-011 cmd_ready  output  1: command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-012 anim_frame  output  4: animation frame index, 0..NUM_FRAMES-1.
REQ-013 sprite_x  output  10: sprite left edge in pixels.
REQ-014 playing  output  1: high in state PLAYING.
REQ-015 frame_update  output  1: one-cycle pulse when anim_frame or sprite_x changes.

Function
REQ-016 FSM states are PAUSED, PLAYING and STEP_PEND; the reset state is PLAYING.
REQ-017 An accepted PAUSE moves any state to PAUSED; an accepted PLAY moves any state to PLAYING.
REQ-018 An accepted STEP from PAUSED moves to STEP_PEND; a STEP accepted in PLAYING is a no-op.
REQ-019 cmd_ready is low in STEP_PEND and high in all other states.
REQ-020 An accepted SET_PERIOD loads period from cmd_data (0 is stored as 1), clears tick_cnt in the same edge, and leaves the state unchanged.
REQ-021 State and registers update on the edge that accepts a command; outputs change only on the edge that samples frame_start.
REQ-022 When a command and frame_start occur in the same cycle, frame_start is evaluated with the pre-command state and period.
REQ-023 In PLAYING, each frame_start increments the 8-bit tick_cnt; when tick_cnt == period-1, tick_cnt clears to 0 and anim_frame advances.
REQ-024 In STEP_PEND, the next frame_start advances anim_frame once, leaves tick_cnt unchanged, and returns the FSM to PAUSED.
REQ-025 In PAUSED, frame_start changes nothing.
REQ-026 anim_frame advances by +1 and wraps from NUM_FRAMES-1 to 0.
REQ-027 frame_update is asserted for exactly the one cycle after the edge in which anim_frame or sprite_x changed; its latency from frame_start is 1 cycle.
REQ-028 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-029 While rst_n is low: state = PLAYING, anim_frame = 0, sprite_x = SPRITE_X_RESET, period = DEFAULT_PERIOD, tick_cnt = 0, frame_update = 0, playing = 1, cmd_ready = 1.
REQ-030 Reset asserted mid-operation (including in STEP_PEND) forces the REQ-029 values immediately, without waiting for clk.
REQ-031 Deassertion is synchronised externally; the first frame_start after reset is handled normally.

Configuration
REQ-032 Macro NYAN_SCROLL_EN defined: in PLAYING, every frame_start increments sprite_x by 1, wrapping from SCROLL_MAX to 0; in STEP_PEND, sprite_x increments once with the step.
REQ-033 NYAN_SCROLL_EN undefined: sprite_x is held constant at SPRITE_X_RESET, and frame_update reflects anim_frame changes only.

Verification
REQ-034 Reset, then 32 frame_start pulses with defaults -> anim_frame goes 0 to 1 at pulse 16 and 1 to 0 at pulse 32; frame_update pulses twice (scroll off).
REQ-035 SET_PERIOD with cmd_data=0, then 3 frame_start pulses -> period is 1; anim_frame toggles on every pulse: 1, 0, 1.
REQ-036 PAUSE, STEP, then cmd_valid held with PLAY -> cmd_ready stays low until the next frame_start; that frame_start advances anim_frame by 1; PLAY is accepted the cycle after, and playing=1.
REQ-037 PAUSE issued in the same cycle as the frame_start with tick_cnt=15 -> anim_frame still advances; no further advance on the following 20 pulses.
REQ-038 NYAN_SCROLL_EN defined, sprite_x=639, frame_start -> sprite_x=0 one cycle later, with frame_update=1 for one cycle.
REQ-039 rst_n pulled low in STEP_PEND between clock edges -> outputs match REQ-029 before the next clk edge.

Source files
------------

// File: rtl/nyan_sequencer.sv
// Animation sequencer: steps a sprite's frame index (and optionally its x position) on vblank pulses.
// Optional horizontal scrolling is enabled by defining NYAN_SCROLL_EN.
module nyan_sequencer #(
    parameter int NUM_FRAMES     = 2,
    parameter int DEFAULT_PERIOD = 16,
    parameter int SPRITE_X_RESET = 128,
    parameter int SCROLL_MAX     = 639
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic [3:0] anim_frame,
    output logic [9:0] sprite_x,
    output logic       playing,
    output logic       frame_update
);

`ifdef NYAN_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {PAUSED = 2'd0, PLAYING = 2'd1, STEP_PEND = 2'd2} state_t;

    localparam logic [1:0] OP_PAUSE      = 2'd0;
    localparam logic [1:0] OP_PLAY       = 2'd1;
    localparam logic [1:0] OP_STEP       = 2'd2;
    localparam logic [1:0] OP_SET_PERIOD = 2'd3;

    state_t     state_q, state_d;
    logic [7:0] period_q, period_d;
    logic [7:0] tick_q, tick_d;
    logic [3:0] anim_q, anim_d, anim_nxt;
    logic [9:0] sprite_q, sprite_d, sprite_nxt;
    logic       update_q, update_d;
    logic       cmd_acc;

    assign cmd_acc    = cmd_valid && cmd_ready;
    assign anim_nxt   = (anim_q == 4'(NUM_FRAMES - 1)) ? 4'd0 : anim_q + 4'd1;
    assign sprite_nxt = (sprite_q == 10'(SCROLL_MAX)) ? 10'd0 : sprite_q + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PLAYING;
            period_q <= 8'(DEFAULT_PERIOD);
            tick_q   <= '0;
            anim_q   <= '0;
            sprite_q <= 10'(SPRITE_X_RESET);
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            anim_q   <= anim_d;
            sprite_q <= sprite_d;
            update_q <= update_d;
        end
    end

    // frame_start is resolved against the current state first; an accepted
    // command then overrides state/period so it takes effect from the next pulse.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        tick_d   = tick_q;
        anim_d   = anim_q;
        sprite_d = sprite_q;

        if (frame_start) begin
            case (state_q)
                PLAYING: begin
                    if (tick_q == period_q - 8'd1) begin
                        tick_d = '0;
                        anim_d = anim_nxt;
                    end else begin
                        tick_d = tick_q + 8'd1;
                    end
                    if (SCROLL_EN) sprite_d = sprite_nxt;
                end
                STEP_PEND: begin
                    anim_d  = anim_nxt;
                    if (SCROLL_EN) sprite_d = sprite_nxt;
                    state_d = PAUSED;
                end
                default: ;
            endcase
        end

        // cmd_ready is low in STEP_PEND, so no command ever races the step above
        if (cmd_acc) begin
            case (cmd_op)
                OP_PAUSE: state_d = PAUSED;
                OP_PLAY:  state_d = PLAYING;
                OP_STEP:  if (state_q == PAUSED) state_d = STEP_PEND;
                OP_SET_PERIOD: begin
                    period_d = (cmd_data == 8'd0) ? 8'd1 : cmd_data;
                    tick_d   = '0;
                end
                default: ;
            endcase
        end

        update_d = (anim_d != anim_q) || (sprite_d != sprite_q);
    end

    assign cmd_ready    = (state_q != STEP_PEND);
    assign playing      = (state_q == PLAYING);
    assign anim_frame   = anim_q;
    assign sprite_x     = sprite_q;
    assign frame_update = update_q;

endmodule
